// File: rtl/matrix_core_pkg.sv
// Shared constants and types for the vector serializer family.
// The SAT14 helper is only used when MATRIX_VEC3_SAT14_EN is defined.
package matrix_core_pkg;

  localparam int LANES_DEF = 3;
  localparam int DW_DEF    = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int SAT14_MAX = 8191;
  localparam int SAT14_MIN = -8192;

  // Clamp a sign-extended lane value to the 14-bit DAC range.
  function automatic int sat14(input int v);
    int r;
    if (v > SAT14_MAX) begin
      r = SAT14_MAX;
    end else if (v < SAT14_MIN) begin
      r = SAT14_MIN;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_lane_sat.sv
// Lane selector with optional 14-bit saturation (MATRIX_VEC3_SAT14_EN).
// Purely combinational; the serializer registers the result.
module matrix_lane_sat
  import matrix_core_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [LANES*DW-1:0] vec_i,
  input  logic [1:0]          idx_i,
  output logic [DW-1:0]       lane_o
);

  logic signed [DW-1:0] sel_s;

  // Pick the lane addressed by idx_i; out-of-range indices read zero.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sel_s = (idx_i == 2'(i)) ? vec_i[i*DW +: DW] : sel_s;
    end
  end

`ifdef MATRIX_VEC3_SAT14_EN
  // Saturate to [-8192, 8191] and sign-extend back to DW.
  always_comb begin
    lane_o = DW'(sat14(int'(sel_s)));
  end
`else
  // Default build passes the lane through bit-for-bit.
  always_comb begin
    lane_o = sel_s;
  end
`endif

endmodule

// File: rtl/matrix_vec3_serializer.sv
// Serializes a packed LANES-wide signed vector into one element per cycle.
// Optional DAC saturation is selected by MATRIX_VEC3_SAT14_EN (see matrix_lane_sat).
module matrix_vec3_serializer
  import matrix_core_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic [LANES*DW-1:0] s_vec_data,
  input  logic                s_vec_valid,
  output logic                s_vec_ready,
  output logic [DW-1:0]       m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [1:0]          m_idx,
  output logic                m_last,
  output logic [15:0]         vec_count
);

  state_e              state_q, state_d;
  logic [LANES*DW-1:0] vec_q, vec_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic [1:0]          m_idx_q, m_idx_d;
  logic                m_last_q, m_last_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                in_xfer_s;
  logic                out_xfer_s;
  logic [LANES*DW-1:0] sel_vec_s;
  logic [1:0]          sel_idx_s;
  logic [DW-1:0]       lane_s;

  assign out_xfer_s  = m_valid_q && m_ready;
  assign s_vec_ready = (state_q == ST_IDLE) || (out_xfer_s && m_last_q);
  assign in_xfer_s   = s_vec_valid && s_vec_ready;

  // A newly accepted vector feeds lane 0 straight from the input so it lands one cycle later.
  assign sel_vec_s = in_xfer_s ? s_vec_data : vec_q;
  assign sel_idx_s = in_xfer_s ? 2'd0 : (m_idx_q + 2'd1);

  matrix_lane_sat #(
    .LANES (LANES),
    .DW    (DW)
  ) u_lane_sat (
    .vec_i  (sel_vec_s),
    .idx_i  (sel_idx_s),
    .lane_o (lane_s)
  );

  // Next-state logic for the FSM, holding register and output registers.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_idx_d   = m_idx_q;
    m_last_d  = m_last_q;
    cnt_d     = cnt_q;
    if (out_xfer_s && m_last_q) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (in_xfer_s) begin
      state_d   = ST_SEND;
      vec_d     = s_vec_data;
      m_valid_d = 1'b1;
      m_idx_d   = 2'd0;
      m_last_d  = (LANES == 1);
      m_data_d  = lane_s;
    end else if (out_xfer_s) begin
      if (m_last_q) begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        m_idx_d   = 2'd0;
        m_last_d  = 1'b0;
        m_data_d  = '0;
      end else begin
        m_idx_d  = sel_idx_s;
        m_last_d = (sel_idx_s == 2'(LANES - 1));
        m_data_d = lane_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_idx_q   <= 2'd0;
      m_last_q  <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_idx_q   <= m_idx_d;
      m_last_q  <= m_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_idx     = m_idx_q;
  assign m_last    = m_last_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_matrix_vec3_serializer.sv
// Directed bench for matrix_vec3_serializer; a second LANES=1 instance exercises the count wrap.
// Expected lane values follow MATRIX_VEC3_SAT14_EN when it is defined.
module tb_matrix_vec3_serializer;

  logic        clk;
  logic        rstn;
  logic [47:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_idx;
  logic        m_last;
  logic [15:0] vcnt;

  logic [15:0] w_sdata;
  logic        w_svalid;
  logic        w_sready;
  logic [15:0] w_mdata;
  logic        w_mvalid;
  logic        w_mready;
  logic [1:0]  w_midx;
  logic        w_mlast;
  logic [15:0] w_vcnt;

  int checks;
  int failures;

  matrix_vec3_serializer dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .s_vec_data      (s_data),
    .s_vec_valid     (s_valid),
    .s_vec_ready     (s_ready),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_idx           (m_idx),
    .m_last          (m_last),
    .vec_count       (vcnt)
  );

  matrix_vec3_serializer #(.LANES(1), .DW(16)) u_wrap (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .s_vec_data      (w_sdata),
    .s_vec_valid     (w_svalid),
    .s_vec_ready     (w_sready),
    .m_data          (w_mdata),
    .m_valid         (w_mvalid),
    .m_ready         (w_mready),
    .m_idx           (w_midx),
    .m_last          (w_mlast),
    .vec_count       (w_vcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                         input logic [1:0] i, input logic l);
    chk({tag, ".valid"}, 32'(m_valid), 32'(v));
    chk({tag, ".data"},  32'(m_data),  32'(d));
    chk({tag, ".idx"},   32'(m_idx),   32'(i));
    chk({tag, ".last"},  32'(m_last),  32'(l));
  endtask

  logic [15:0] exp_d;

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    s_data   = 48'd0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    w_sdata  = 16'd0;
    w_svalid = 1'b0;
    w_mready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_out("rst", 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("rst.cnt", 32'(vcnt), 32'd0);
    chk("rst.ready", 32'(s_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel.ready", 32'(s_ready), 32'd1);

    // Single vector with m_ready high
    s_data  = {16'h0003, 16'hFFFE, 16'h0001};
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk_out("single.l0", 1'b1, 16'h0001, 2'd0, 1'b0);
    chk("single.l0.ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk_out("single.l1", 1'b1, 16'hFFFE, 2'd1, 1'b0);
    @(negedge clk);
    chk_out("single.l2", 1'b1, 16'h0003, 2'd2, 1'b1);
    chk("single.l2.ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk_out("single.idle", 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("single.cnt", 32'(vcnt), 32'd1);

    // Back-to-back: vector k lane j = 0x0100*(k+1) + j, twelve contiguous elements
    s_data  = {16'h0102, 16'h0101, 16'h0100};
    s_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        exp_d = 16'h0100 * 16'(k + 1) + 16'(j);
        chk_out("b2b", 1'b1, exp_d, 2'(j), (j == 2));
        chk("b2b.ready", 32'(s_ready), 32'(j == 2));
        if (j == 2) begin
          if (k < 3) begin
            s_data = {16'h0100 * 16'(k + 2) + 16'd2,
                      16'h0100 * 16'(k + 2) + 16'd1,
                      16'h0100 * 16'(k + 2)};
          end else begin
            s_valid = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
    chk("b2b.end.valid", 32'(m_valid), 32'd0);
    chk("b2b.cnt", 32'(vcnt), 32'd5);  // one earlier vector plus four

    // Backpressure on lane 1 for five cycles
    s_data  = {16'h3333, 16'h2222, 16'h1111};
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk_out("bp.l0", 1'b1, 16'h1111, 2'd0, 1'b0);
    @(negedge clk);
    chk_out("bp.l1", 1'b1, 16'h2222, 2'd1, 1'b0);
    m_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk_out("bp.hold", 1'b1, 16'h2222, 2'd1, 1'b0);
      chk("bp.hold.ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk_out("bp.l2", 1'b1, 16'h3333, 2'd2, 1'b1);
    @(negedge clk);
    chk("bp.cnt", 32'(vcnt), 32'd6);

    // Reset while lane 1 is on the output
    s_data  = {16'h0333, 16'h0222, 16'h0111};
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk_out("mid.l0", 1'b1, 16'h0111, 2'd0, 1'b0);
    @(negedge clk);
    chk_out("mid.l1", 1'b1, 16'h0222, 2'd1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk_out("mid.rst", 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("mid.rst.cnt", 32'(vcnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("mid.rel.ready", 32'(s_ready), 32'd1);
    s_data  = {16'h000C, 16'h000B, 16'h000A};
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk_out("mid.new.l0", 1'b1, 16'h000A, 2'd0, 1'b0);
    @(negedge clk);
    chk_out("mid.new.l1", 1'b1, 16'h000B, 2'd1, 1'b0);
    @(negedge clk);
    chk_out("mid.new.l2", 1'b1, 16'h000C, 2'd2, 1'b1);
    @(negedge clk);
    chk("mid.new.cnt", 32'(vcnt), 32'd1);

    // Saturation boundary lanes
    s_data  = {16'h1000, 16'h8000, 16'h7FFF};
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
`ifdef MATRIX_VEC3_SAT14_EN
    chk_out("sat.l0", 1'b1, 16'h1FFF, 2'd0, 1'b0);
    @(negedge clk);
    chk_out("sat.l1", 1'b1, 16'hE000, 2'd1, 1'b0);
`else
    chk_out("sat.l0", 1'b1, 16'h7FFF, 2'd0, 1'b0);
    @(negedge clk);
    chk_out("sat.l1", 1'b1, 16'h8000, 2'd1, 1'b0);
`endif
    @(negedge clk);
    chk_out("sat.l2", 1'b1, 16'h1000, 2'd2, 1'b1);
    @(negedge clk);
    chk("sat.cnt", 32'(vcnt), 32'd2);

    // Count wrap on the single-lane instance: 65535 vectors, then one more
    w_sdata  = 16'h0042;
    w_svalid = 1'b1;
    w_mready = 1'b1;
    repeat (65536) @(negedge clk);
    chk("wrap.pre.cnt", 32'(w_vcnt), 32'hFFFF);
    chk("wrap.pre.valid", 32'(w_mvalid), 32'd1);
    chk("wrap.pre.last", 32'(w_mlast), 32'd1);
    chk("wrap.pre.idx", 32'(w_midx), 32'd0);
    chk("wrap.pre.data", 32'(w_mdata), 32'h0042);
    w_svalid = 1'b0;
    @(negedge clk);
    chk("wrap.cnt", 32'(w_vcnt), 32'd0);
    chk("wrap.valid", 32'(w_mvalid), 32'd0);
    chk("wrap.ready", 32'(w_sready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_vec3_serializer.md
MATRIX_VEC3_SERIALIZER -- requirements
Module: matrix_vec3_serializer

Interface
REQ-001 SHALL have parameter LANES, default 3, giving the number of lanes per vector.
REQ-002 SHALL have parameter DW, default 16, giving the width of each signed lane.
REQ-003 SHALL have port system1000  in  1  clock; all state on rising edge.
REQ-004 SHALL have port system1000_rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_vec_data  in  LANES*DW  packed vector; lane i at bits [i*DW +: DW].
REQ-006 SHALL have port s_vec_valid  in  1  input vector valid.
REQ-007 SHALL have port s_vec_ready  out  1  block accepts vector this cycle.
REQ-008 SHALL have port m_data  out  DW  signed element stream.
REQ-009 SHALL have port m_valid  out  1  m_data valid.
REQ-010 SHALL have port m_ready  in  1  downstream accepts element.
REQ-011 SHALL have port m_idx  out  2  lane index of current element.
REQ-012 SHALL have port m_last  out  1  high on lane LANES-1.
REQ-013 SHALL have port vec_count  out  16  count of vectors fully emitted, wraps modulo 2^16.

Function
REQ-014 SHALL transfer on the input side when s_vec_valid && s_vec_ready, and on the output side when m_valid && m_ready.
REQ-015 SHALL implement FSM IDLE/SEND: IDLE->SEND on input transfer; SEND->IDLE on transfer of last lane with no simultaneous input transfer; SEND->SEND otherwise.
REQ-016 SHALL drive s_vec_ready = (state==IDLE) || (m_valid && m_ready && m_last), the only combinational in-to-out path.
REQ-017 SHALL capture s_vec_data into a holding register on input transfer; lane 0 appears on m_data the next cycle (latency 1).
REQ-018 SHALL emit lanes in order 0..LANES-1; m_idx increments only on output transfer and resets to 0 on each new vector.
REQ-019 SHALL sustain one element per cycle with no bubble between back-to-back vectors when m_ready and s_vec_valid stay high.
REQ-020 SHALL hold m_data, m_idx, m_last and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL keep m_valid low in IDLE; m_data, m_idx and m_last are don't-care-free and read 0 there.
REQ-022 SHALL reinterpret each lane as two's-complement signed DW bits, with no arithmetic in the default build.
REQ-023 SHALL increment vec_count on transfer of the last lane; 16'hFFFF wraps to 0.

Reset
REQ-024 SHALL on system1000_rstn low, asynchronously, force state=IDLE, m_valid=0, m_data=0, m_idx=0, m_last=0, vec_count=0 and the holding register to 0.
REQ-025 SHALL discard a partially emitted vector when reset asserts mid-vector; after release, s_vec_ready=1 in the first cycle.

Configuration
REQ-026 SHALL with macro MATRIX_VEC3_SAT14_EN defined, saturate each emitted lane to the signed 14-bit range [-8192, 8191] and sign-extend it to DW, for the DAC path.
REQ-027 SHALL without MATRIX_VEC3_SAT14_EN, pass lanes unmodified; ports and timing are identical in both builds.

Structure
REQ-028 SHALL place LANES/DW defaults, the FSM state enum and the SAT14 limit constants in shared package matrix_core_pkg.
REQ-029 SHALL place per-lane selection plus optional saturation in sub-module matrix_lane_sat; FSM, counters and handshake stay in the top module.

Verification
REQ-030 SHALL cover single vector, m_ready=1: input {16'h0003,16'hFFFE,16'h0001} -> m_data 0x0001, 0xFFFE, 0x0003 in consecutive cycles starting 1 cycle after acceptance, m_idx 0,1,2, m_last on third, vec_count=1.
REQ-031 SHALL cover back-to-back: 4 vectors with s_vec_valid and m_ready held high -> 12 contiguous m_valid cycles, s_vec_ready pulses with each m_last, vec_count=4.
REQ-032 SHALL cover backpressure: m_ready low for 5 cycles on lane 1 -> m_data/m_idx held at lane 1 value, s_vec_ready=0, no lane lost.
REQ-033 SHALL cover reset mid-vector: rstn low after lane 0 emitted -> all outputs 0 immediately, vec_count=0; next vector emits from lane 0.
REQ-034 SHALL cover wrap: vec_count preset by 65535 vectors, one more -> vec_count=0.
REQ-035 SHALL cover SAT14 build: lanes 0x7FFF, 0x8000, 0x1000 -> 0x1FFF, 0xE000, 0x1000; default build -> unchanged.
